// File: rtl/qiangda_keypad_if.sv
// Contestant/judge buttons and the conditioned requests sent on to the quiz controller.
interface qiangda_keypad_if;
  logic [3:0] key_raw;
  logic       add_raw;
  logic       stu_raw;
  logic [3:0] in;
  logic       add;
  logic       stu;
  logic       lock;
  logic [3:0] lamp;

  // Button side drives raw inputs and observes the conditioned outputs.
  modport master (
    output key_raw, add_raw, stu_raw,
    input  in, add, stu, lock, lamp
  );

  // Keypad front end.
  modport slave (
    input  key_raw, add_raw, stu_raw,
    output in, add, stu, lock, lamp
  );
endinterface

// File: rtl/qiangda_keypad.sv
// Quiz-buzzer front end: synchronise and debounce buttons, arbitrate the first
// contestant press, hold a one-hot request, then lock out until the judge scores.
module qiangda_keypad #(
  parameter int unsigned DEB_CYCLES  = 8,
  parameter int unsigned HOLD_CYCLES = 4
) (
  input logic              clk,
  input logic              clr,
  qiangda_keypad_if.slave  bus
);

  localparam int unsigned DW = $clog2(DEB_CYCLES + 1);
  localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StSend   = 2'd1;
  localparam logic [1:0] StLocked = 2'd2;

  // Bit order: {key[3:0], add, stu}.
  logic [5:0]         raw;
  logic [5:0]         sync1_q, sync2_q;
  logic [5:0]         deb_q, deb_d;
  logic [5:0]         deb_prev_q;
  logic [5:0]         press_q;
  logic [5:0][DW-1:0] cnt_q, cnt_d;

  logic [1:0]    state_q, state_d;
  logic [3:0]    winner_q, winner_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [3:0]    key_press;
  logic          judge_ev;

  assign raw       = {bus.key_raw, bus.add_raw, bus.stu_raw};
  assign key_press = press_q[5:2];
  assign judge_ev  = press_q[1] | press_q[0];

  // Debounce: count consecutive mismatching samples, adopt the new level once stable.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    for (int i = 0; i < 6; i++) begin
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == DW'(DEB_CYCLES - 1)) begin
          deb_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Arbitration FSM; press events outside IDLE are simply dropped.
  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    hold_d   = hold_q;
    case (state_q)
      StIdle: begin
        if (|key_press) begin
          state_d = StSend;
          hold_d  = '0;
          if (key_press[3])      winner_d = 4'b1000;
          else if (key_press[2]) winner_d = 4'b0100;
          else if (key_press[1]) winner_d = 4'b0010;
          else                   winner_d = 4'b0001;
        end
      end
      StSend: begin
        // Judge pulses here are emitted but never shorten the hold.
        if (hold_q == HW'(HOLD_CYCLES - 1)) begin
          state_d = StLocked;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      StLocked: begin
        if (judge_ev) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State, synchronisers, debounce and edge-detect registers.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      press_q    <= '0;
      cnt_q      <= '0;
      state_q    <= StIdle;
      winner_q   <= '0;
      hold_q     <= '0;
    end else begin
      sync1_q    <= raw;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      press_q    <= deb_q & ~deb_prev_q;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      winner_q   <= winner_d;
      hold_q     <= hold_d;
    end
  end

  assign bus.in   = (state_q == StSend) ? winner_q : 4'b0000;
  assign bus.lock = (state_q == StSend) || (state_q == StLocked);
  assign bus.lamp = bus.lock ? winner_q : 4'b0000;
  assign bus.add  = press_q[1];
  // add wins a same-cycle tie.
  assign bus.stu  = press_q[0] & ~press_q[1];

endmodule

// File: doc/qiangda_keypad.md
Name: qiangda_keypad

Overview:
- Contestant- and judge-side front end for the quiz-buzzer controller; it produces the controller's `in`, `add` and `stu` inputs.
- Synchronises and debounces four raw contestant buttons and the two judge buttons.
- Arbitrates the first contestant press and presents a clean one-hot request on `in`, then locks out further presses until the judge scores.
- Drives the contestant lamps so each station can see who won.

Parameters:
- DEB_CYCLES, 8: consecutive stable synchronised samples required before a debounced level changes (≥2).
- HOLD_CYCLES, 4: number of clk cycles the one-hot `in` request is held (≥1).

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- clr  input  1  asynchronous active-high reset.
- key_raw  input  4  raw contestant buttons, active-high; bit3 = contestant 1 … bit0 = contestant 4.
- add_raw  input  1  raw judge "add point" button, active-high.
- stu_raw  input  1  raw judge "subtract point" button, active-high.
- in  output  4  one-hot contestant request to the controller; 4'b0000 when idle.
- add  output  1  single-cycle add pulse.
- stu  output  1  single-cycle subtract pulse.
- lock  output  1  high while a contestant owns the floor (SEND or LOCKED).
- lamp  output  4  lamp for the winning contestant, same bit order as `in`.

Behaviour:
- Reset (clr high, asynchronous):
  - in, add, stu, lock and lamp are all 0.
  - State is IDLE.
  - Synchronisers, debounced levels and all counters are 0.
- Input conditioning, per input (4 keys, add, stu):
  - 2-flop synchroniser, then a debounce counter.
  - The counter increments while the synchronised value differs from the debounced level and clears to 0 when they match.
  - When the counter reaches DEB_CYCLES, the debounced level takes the synchronised value and the counter clears.
  - Glitches shorter than DEB_CYCLES samples never change the debounced level.
- Press event: a 0→1 transition of the debounced level, registered as a 1-cycle pulse. A 1→0 transition generates nothing.
- Latency: for a clean key, `in` asserts exactly DEB_CYCLES+3 rising edges after the first edge at which key_raw is sampled high.
- FSM IDLE: in=0, lamp=0, lock=0.
  - On any key press event, select the winner by fixed priority bit3 > bit2 > bit1 > bit0.
  - Same-cycle presses always yield exactly one winner, so `in` is never multi-hot.
  - Go to SEND.
- FSM SEND:
  - in = winner one-hot, lamp = winner, lock = 1.
  - Hold for exactly HOLD_CYCLES cycles, then go to LOCKED.
- FSM LOCKED:
  - in = 0, lamp = winner, lock = 1.
  - On an add or stu pulse, go to IDLE the next cycle; lamp and lock clear on that edge.
- Press events in SEND or LOCKED are discarded; there is no queue.
- A key still held on return to IDLE does not retrigger. It must be released and pressed again.
- add/stu pulses:
  - Emitted in any state: one cycle high per debounced rising edge of add_raw/stu_raw.
  - If both fire in the same cycle, add is emitted and stu is suppressed.
- SEND exit: an add/stu pulse during SEND is emitted but does not shorten SEND. The FSM still goes to LOCKED, and waits there for the next judge pulse.
- Mid-operation reset:
  - Returns to IDLE immediately with outputs at 0; the winner is discarded.
  - A key held through reset is debounced from level 0 afterwards, so it produces a fresh press DEB_CYCLES+3 edges after clr falls.
- Counters use width ceil(log2(max+1)). The HOLD counter counts 0..HOLD_CYCLES-1 and never wraps.

Test Plan:
- Defaults; clean key_raw=4'b0100 from cycle 0 → in=4'b0100 at edge 11 for 4 cycles; lamp=4'b0100 and lock=1 from edge 11 until judge action.
- key_raw=4'b0011 rising same cycle → in=4'b0010 only, never 4'b0011.
- key_raw[3] bounces 1/0 every 3 cycles for 20 cycles, then stable high → no `in` activity until 11 edges after the final stable rise, then in=4'b1000.
- While LOCKED on 4'b1000, press key_raw[0] → `in` stays 0000; then add_raw clean press → add high exactly 1 cycle, lock and lamp clear the following edge.
- add_raw and stu_raw pressed same cycle → add one pulse, stu stays 0.
- clr pulse during SEND → in, lamp, lock = 0 asynchronously; with the key held, in re-asserts 11 edges after clr deasserts.
